// File: rtl/lcd_timing_driver_if.sv
// Panel-side bundle of the LCD timing driver: pixel fetch request/response
// toward the frame source plus the sync/data signals toward the panel.
interface lcd_timing_driver_if;
   logic [23:0] pixel_data;
   logic        data_req;
   logic [10:0] pixel_xpos;
   logic [10:0] pixel_ypos;
   logic        lcd_hs;
   logic        lcd_vs;
   logic        lcd_de;
   logic [23:0] lcd_rgb;
   logic        frame_start;

   modport master (
      input  pixel_data,
      output data_req, pixel_xpos, pixel_ypos,
      output lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_start
   );

   modport slave (
      output pixel_data,
      input  data_req, pixel_xpos, pixel_ypos,
      input  lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_start
   );
endinterface

// File: rtl/lcd_timing_driver.sv
// Free-running RGB panel timing generator: pixel-clock divider, h/v counters,
// sync/enable decodes and a one-pixel prefetch of pixel_data into lcd_rgb.
module lcd_timing_driver #(
   parameter int CLK_DIV = 2,
   parameter int H_SYNC  = 96,
   parameter int H_BACK  = 48,
   parameter int H_DISP  = 640,
   parameter int H_FRONT = 16,
   parameter int V_SYNC  = 2,
   parameter int V_BACK  = 33,
   parameter int V_DISP  = 480,
   parameter int V_FRONT = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   lcd_timing_driver_if.master   bus
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
   localparam int HA      = H_SYNC + H_BACK;
   localparam int VA      = V_SYNC + V_BACK;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
   localparam logic [10:0] V_SYNC_END = 11'(V_SYNC);
   localparam logic [10:0] DE_H_BEG   = 11'(HA);
   localparam logic [10:0] DE_H_END   = 11'(HA + H_DISP);
   localparam logic [10:0] REQ_H_BEG  = 11'(HA - 1);
   localparam logic [10:0] REQ_H_END  = 11'(HA + H_DISP - 1);
   localparam logic [10:0] DE_V_BEG   = 11'(VA);
   localparam logic [10:0] DE_V_END   = 11'(VA + V_DISP);

   logic [DIV_W-1:0] div_q, div_d;
   logic [10:0]      h_q, h_d;
   logic [10:0]      v_q, v_d;
   logic [23:0]      rgb_q, rgb_d;
   logic             fs_q, fs_d;
   logic             pix_en, h_wrap, v_wrap;
   logic             row_act, req;

   // NOTE: every combinational output gets its default before any branch, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      pix_en = (div_q == DIV_LAST);
      h_wrap = (h_q == H_LAST);
      v_wrap = (v_q == V_LAST);
      div_d  = pix_en ? '0 : div_q + DIV_W'(1);
      h_d    = h_q;
      v_d    = v_q;
      rgb_d  = rgb_q;
      fs_d   = pix_en && h_wrap && v_wrap;

      row_act = (v_q >= DE_V_BEG) && (v_q < DE_V_END);
      req     = row_act && (h_q >= REQ_H_BEG) && (h_q < REQ_H_END);

      if (pix_en) begin
         h_d = h_wrap ? '0 : h_q + 11'd1;
         if (h_wrap) v_d = v_wrap ? '0 : v_q + 11'd1;
         // The column requested now is shown after this pixel edge, so the
         // request and load happen together; outside the request window the
         // panel sees black.
         rgb_d = req ? bus.pixel_data : '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
         h_q   <= '0;
         v_q   <= '0;
         rgb_q <= '0;
         fs_q  <= 1'b0;
      end else begin
         div_q <= div_d;
         h_q   <= h_d;
         v_q   <= v_d;
         rgb_q <= rgb_d;
         fs_q  <= fs_d;
      end
   end

   // Pure decodes of the registered counters, so they only move on pixel edges.
   assign bus.lcd_hs      = (h_q >= H_SYNC_END);
   assign bus.lcd_vs      = (v_q >= V_SYNC_END);
   assign bus.lcd_de      = row_act && (h_q >= DE_H_BEG) && (h_q < DE_H_END);
   assign bus.data_req    = req;
   assign bus.pixel_xpos  = req ? h_q - REQ_H_BEG : '0;
   assign bus.pixel_ypos  = req ? v_q - DE_V_BEG  : '0;
   assign bus.lcd_rgb     = rgb_q;
   assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_lcd_timing_driver.sv
// Scoreboard bench for lcd_timing_driver on a shrunken panel (CLK_DIV=2) plus
// a CLK_DIV=1 tiny panel; pixel_data encodes its own coordinates.
module tb_lcd_timing_driver;

   // Panel 1: H 3/2/4/2 (total 11, HA 5), V 2/1/3/1 (total 7, VA 3), CLK_DIV 2.
   localparam int CD        = 2;
   localparam int LINE_CLKS = 22;
   localparam int FRAME_CLKS = 154;
   localparam int HS_W      = 6;
   localparam int VS_W      = 44;
   localparam int REQ_RISE  = 8;
   localparam int REQ_FALL  = 16;
   localparam int DE_RISE   = 10;
   localparam int DE_FALL   = 18;
   localparam int DISP_ROWS = 3;
   localparam int DISP_COLS = 4;
   localparam logic [23:0] TARGET = {8'd1, 11'd2, 5'd0};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lcd_timing_driver_if bus1 ();
   lcd_timing_driver_if bus2 ();

   assign bus1.pixel_data = {bus1.pixel_ypos[7:0], bus1.pixel_xpos, 5'b0};
   assign bus2.pixel_data = {bus2.pixel_ypos[7:0], bus2.pixel_xpos, 5'b0};

   lcd_timing_driver #(
      .CLK_DIV(2), .H_SYNC(3), .H_BACK(2), .H_DISP(4), .H_FRONT(2),
      .V_SYNC(2), .V_BACK(1), .V_DISP(3), .V_FRONT(1)
   ) dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

   lcd_timing_driver #(
      .CLK_DIV(1), .H_SYNC(2), .H_BACK(1), .H_DISP(4), .H_FRONT(1),
      .V_SYNC(1), .V_BACK(1), .V_DISP(2), .V_FRONT(1)
   ) dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic timeout(input string name);
      n_checks++;
      $display("FAIL %s: got timeout, expected event", name);
   endtask

   // ---------------- scoreboard for panel 1 pixels ----------------
   logic [23:0] exp_q[$];
   logic [23:0] exp_pix;
   int run1 = 0;

   task automatic push_frames(input int n);
      for (int f = 0; f < n; f++)
         for (int y = 0; y < DISP_ROWS; y++)
            for (int x = 0; x < DISP_COLS; x++)
               exp_q.push_back({8'(y), 11'(x), 5'b0});
   endtask

   initial forever begin
      @(negedge clk);
      if (rst) run1 = 0;
      else if (bus1.lcd_de) begin
         if (run1 % CD == 0) begin
            if (exp_q.size() == 0) timeout("sb_underflow");
            else begin
               exp_pix = exp_q.pop_front();
               check("pixel_rgb", bus1.lcd_rgb, exp_pix);
            end
         end
         run1++;
      end else run1 = 0;
   end

   // ---------------- timing monitor for panel 1 ----------------
   int t, hs_fall_t, vs_fall_t, fs_t, req_t, de_lines;
   int xy_viol = 0, rgb_viol = 0, fs_viol = 0;
   logic hs_p, vs_p, fs_p, req_p, de_p;

   initial forever begin
      @(negedge clk);
      if (rst) begin
         t = 0; hs_fall_t = 0; vs_fall_t = 0; fs_t = 0; req_t = 0; de_lines = 0;
         hs_p = 1'b0; vs_p = 1'b0; fs_p = 1'b0; req_p = 1'b0; de_p = 1'b0;
      end else begin
         t++;
         if (!hs_p && bus1.lcd_hs) check("hs_low_width", t - hs_fall_t, HS_W);
         if (hs_p && !bus1.lcd_hs) begin
            check("line_period", t - hs_fall_t, LINE_CLKS);
            hs_fall_t = t;
         end
         if (!vs_p && bus1.lcd_vs) check("vs_low_width", t - vs_fall_t, VS_W);
         if (vs_p && !bus1.lcd_vs) begin
            check("vs_period", t - vs_fall_t, FRAME_CLKS);
            vs_fall_t = t;
         end
         if (!req_p && bus1.data_req) begin
            check("req_rise_pos", t - hs_fall_t, REQ_RISE);
            req_t = t;
         end
         if (req_p && !bus1.data_req) check("req_fall_pos", t - hs_fall_t, REQ_FALL);
         if (!de_p && bus1.lcd_de) begin
            check("de_lead", t - req_t, CD);
            check("de_rise_pos", t - hs_fall_t, DE_RISE);
            de_lines++;
         end
         if (de_p && !bus1.lcd_de) check("de_fall_pos", t - hs_fall_t, DE_FALL);
         if (bus1.frame_start && fs_p) fs_viol++;
         if (bus1.frame_start && !fs_p) begin
            check("frame_period", t - fs_t, FRAME_CLKS);
            check("de_lines", de_lines, DISP_ROWS);
            fs_t = t;
            de_lines = 0;
         end
         if (!bus1.data_req && (bus1.pixel_xpos != 0 || bus1.pixel_ypos != 0)) xy_viol++;
         if (!bus1.lcd_de && bus1.lcd_rgb != 0) rgb_viol++;
         hs_p = bus1.lcd_hs; vs_p = bus1.lcd_vs; fs_p = bus1.frame_start;
         req_p = bus1.data_req; de_p = bus1.lcd_de;
      end
   end

   // ---------------- direct monitor for CLK_DIV=1 panel ----------------
   int run2 = 0, y2 = 0, rgb2_viol = 0;

   initial forever begin
      @(negedge clk);
      if (rst) begin
         run2 = 0; y2 = 0;
      end else if (bus2.lcd_de) begin
         check("div1_rgb", bus2.lcd_rgb, {8'(y2), 11'(run2), 5'b0});
         run2++;
      end else begin
         if (run2 != 0) begin
            check("div1_de_run", run2, 4);
            y2 = (y2 + 1) % 2;
         end
         run2 = 0;
         if (bus2.lcd_rgb != 0) rgb2_viol++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_fs(input int n, input int budget, input string name);
      int cnt = 0;
      for (int i = 0; i < budget && cnt < n; i++) begin
         @(negedge clk);
         if (bus1.frame_start) cnt++;
      end
      if (cnt < n) timeout(name);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_hs"},   bus1.lcd_hs, 1'b0);
      check({tag, "_vs"},   bus1.lcd_vs, 1'b0);
      check({tag, "_de"},   bus1.lcd_de, 1'b0);
      check({tag, "_req"},  bus1.data_req, 1'b0);
      check({tag, "_xpos"}, bus1.pixel_xpos, 11'd0);
      check({tag, "_ypos"}, bus1.pixel_ypos, 11'd0);
      check({tag, "_rgb"},  bus1.lcd_rgb, 24'd0);
      check({tag, "_fs"},   bus1.frame_start, 1'b0);
      check({tag, "_de2"},  bus2.lcd_de, 1'b0);
      check({tag, "_rgb2"}, bus2.lcd_rgb, 24'd0);
   endtask

   initial begin
      bit found;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");

      push_frames(3);
      #1 rst = 1'b0;
      wait_fs(2, 2 * FRAME_CLKS + 20, "first_two_frames");

      // Interrupt the third frame at row 1, column 2, between clock edges.
      found = 1'b0;
      for (int i = 0; i < FRAME_CLKS && !found; i++) begin
         @(negedge clk);
         if (bus1.lcd_de && bus1.lcd_rgb == TARGET) found = 1'b1;
      end
      if (!found) timeout("mid_frame_target");
      #2 rst = 1'b1;
      #1 check_reset_outputs("async_reset");
      exp_q.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
      push_frames(1);
      @(negedge clk);
      check("restart_hs_low", bus1.lcd_hs, 1'b0);
      check("restart_no_fs", bus1.frame_start, 1'b0);
      wait_fs(1, FRAME_CLKS + 20, "frame_after_reset");
      repeat (10) @(negedge clk);

      check("sb_drained", exp_q.size(), 0);
      check("xy_zero_when_idle", xy_viol, 0);
      check("rgb_zero_outside_de", rgb_viol, 0);
      check("frame_start_one_clk", fs_viol, 0);
      check("div1_rgb_zero_outside_de", rgb2_viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lcd_timing_driver.md
LCD_TIMING_DRIVER -- requirements
Module: lcd_timing_driver

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with the ports listed in REQ-002 to REQ-012.
REQ-002 clk  input  1  system clock, 50 MHz; all state SHALL be on its rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 pixel_data  input  24  RGB888 pixel supplied by the frame source for the coordinate on pixel_xpos/pixel_ypos.
REQ-005 data_req  output  1  request for pixel_data, asserted one pixel period ahead of lcd_de.
REQ-006 pixel_xpos  output  11  active-area column being requested; 0 when data_req is low.
REQ-007 pixel_ypos  output  11  active-area row being requested; 0 when data_req is low.
REQ-008 lcd_hs  output  1  horizontal sync, active low.
REQ-009 lcd_vs  output  1  vertical sync, active low.
REQ-010 lcd_de  output  1  data enable, active high.
REQ-011 lcd_rgb  output  24  pixel to panel.
REQ-012 frame_start  output  1  one-clk pulse at wrap to h_cnt=0, v_cnt=0.
REQ-013 Parameters (name, default, meaning):
- CLK_DIV, 2, clk cycles per pixel (>=1).
- H_SYNC, 96, hsync width in pixels.
- H_BACK, 48, horizontal back porch.
- H_DISP, 640, active width.
- H_FRONT, 16, horizontal front porch.
- V_SYNC, 2, vsync width in lines.
- V_BACK, 33, vertical back porch.
- V_DISP, 480, active height.
- V_FRONT, 10, vertical front porch.
- Derived: H_TOTAL=sum of H_*, V_TOTAL=sum of V_*.

Function
REQ-014 div_cnt SHALL count 0..CLK_DIV-1 and wrap; pix_en SHALL be high for the single clk where div_cnt==CLK_DIV-1.
REQ-015 h_cnt (11 bit) SHALL advance only when pix_en is high, wrapping from H_TOTAL-1 to 0.
REQ-016 v_cnt (11 bit) SHALL increment on each h_cnt wrap, wrapping from V_TOTAL-1 to 0.
REQ-017 Define HA=H_SYNC+H_BACK and VA=V_SYNC+V_BACK.
REQ-018 lcd_hs SHALL be low iff h_cnt<H_SYNC, and lcd_vs SHALL be low iff v_cnt<V_SYNC.
REQ-019 lcd_de SHALL be high iff HA<=h_cnt<HA+H_DISP and VA<=v_cnt<VA+V_DISP.
REQ-020 data_req SHALL be high iff HA-1<=h_cnt<HA+H_DISP-1 and v_cnt is in the lcd_de row range.
REQ-021 While data_req is high, pixel_xpos SHALL equal h_cnt-(HA-1) and pixel_ypos SHALL equal v_cnt-VA.
REQ-022 lcd_hs, lcd_vs, lcd_de, data_req, pixel_xpos and pixel_ypos SHALL be pure decodes of the registered counters, so they change only on pix_en edges.
REQ-023 On each pix_en edge, lcd_rgb SHALL load pixel_data if data_req was high, and SHALL load 0 otherwise.
REQ-024 Per REQ-023, lcd_rgb SHALL hold the pixel for column x exactly while lcd_de is high at that column, and SHALL be 0 whenever lcd_de is low.
REQ-025 pixel_data SHALL only be sampled on pix_en edges and SHALL be ignored on all other cycles.
REQ-026 frame_start SHALL be registered high for exactly one clk on the edge where pix_en=1, h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1.
REQ-027 There SHALL be no handshake stall: the frame source SHALL provide data combinationally or with one-pixel prefetch, and the timing SHALL never pause.

Reset
REQ-028 While rst is high, div_cnt, h_cnt, v_cnt, lcd_rgb and frame_start SHALL be 0.
REQ-029 While rst is high, the outputs SHALL therefore be lcd_hs=0, lcd_vs=0, lcd_de=0, data_req=0 and pixel_xpos=pixel_ypos=0.
REQ-030 Assertion of rst mid-frame SHALL take effect immediately, without waiting for a clk edge.
REQ-031 After rst deasserts, the first pix_en SHALL occur CLK_DIV clks later, and timing SHALL restart from h_cnt=0, v_cnt=0.
REQ-032 After rst deasserts, no frame_start SHALL be emitted until the first full-frame wrap.

Verification (defaults, CLK_DIV=2)
REQ-033 Release reset, then count clk cycles -> each lcd_hs low pulse SHALL be 192 clks and each line SHALL be 1600 clks.
REQ-034 Run two frames -> frame_start pulses SHALL be 840000 clks apart, and lcd_vs low SHALL last 3200 clks.
REQ-035 Drive pixel_data={pixel_ypos[7:0],pixel_xpos[10:0],5'b0} -> on every lcd_de cycle, lcd_rgb SHALL match the panel position, with 640 de pixels per line and 480 de lines per frame.
REQ-036 Observe data_req -> it SHALL rise at h_cnt=143 and fall at h_cnt=783, and lcd_de SHALL span h_cnt 144..783.
REQ-037 Assert rst at line 200, pixel 300 for 3 clks -> all outputs SHALL go to reset values asynchronously, and the next hs low SHALL begin at the first clk edge after release.
REQ-038 Set CLK_DIV=1 with H_DISP=4 and V_DISP=2 -> lcd_de SHALL be high for exactly 4 consecutive clks per active line and lcd_rgb SHALL be 0 outside them.
